// File: rtl/tecb_pkg.sv
// Shared types and helpers for the tagged event counter bank.
// Build option: EVT_COUNT_SAT_EN makes the channel counters saturate instead of wrap.
package tecb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCRUB  = 2'd1,
        COMMIT = 2'd2
    } tecb_state_t;

    // Callers zero-extend their levels to this width so one helper serves any LW.
    localparam int LVL_FN_W = 16;

    function automatic logic lvl_dominates(input logic [LVL_FN_W-1:0] a,
                                           input logic [LVL_FN_W-1:0] b);
        return a >= b;
    endfunction

    function automatic int chw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tecb_channel.sv
// One channel of the bank: event counter plus its committed security level.
// Build option: EVT_COUNT_SAT_EN selects saturating counting; default wraps.
module tecb_channel
    import tecb_pkg::*;
#(
    parameter int CW = 4,
    parameter int LW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clear,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic [LW-1:0] lvl
);

    // A clear wins over an increment so a scrubbing channel stays at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
`ifdef EVT_COUNT_SAT_EN
            if (cnt != {CW{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
`else
            cnt <= cnt + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
        end else if (load) begin
            lvl <= load_val;
        end
    end

endmodule

// File: rtl/tagged_event_counter_bank.sv
// Bank of labelled event counters: level downgrades scrub the counter before committing.
// Build option: EVT_COUNT_SAT_EN (saturating counters, handled in tecb_channel).
module tagged_event_counter_bank
    import tecb_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CW        = 4,
    parameter int LW        = 1,
    parameter int SCRUB_CYC = 2,
    localparam int CHW      = chw_of(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    evt,
    input  logic              lvl_wr_valid,
    output logic              lvl_wr_ready,
    input  logic [CHW-1:0]    lvl_wr_ch,
    input  logic [LW-1:0]     lvl_wr_val,
    input  logic              rd_valid,
    input  logic [CHW-1:0]    rd_ch,
    input  logic [LW-1:0]     rd_lvl,
    output logic              rd_resp_valid,
    output logic [CW-1:0]     rd_data,
    output logic              rd_denied,
    output logic [NCH*LW-1:0] ch_lvl
);

    localparam int SCW = $clog2(SCRUB_CYC + 1);

    tecb_state_t    state;
    tecb_state_t    next_state;
    logic [SCW-1:0] scrub_cnt;
    logic [CHW-1:0] lat_ch;
    logic [LW-1:0]  lat_val;
    logic [CW-1:0]  cnt [NCH];
    logic [LW-1:0]  lvl [NCH];
    logic [NCH-1:0] ch_clear;
    logic [NCH-1:0] ch_load;
    logic [LW-1:0]  load_val;
    logic [LW-1:0]  wr_cur_lvl;
    logic [LW-1:0]  rd_cur_lvl;
    logic [CW-1:0]  rd_cur_cnt;
    logic           wr_in_range;
    logic           rd_in_range;
    logic           accept;
    logic           upgrade;
    logic           downgrade;
    logic           scrub_done;

    assign wr_in_range = {1'b0, lvl_wr_ch} < (CHW+1)'(NCH);
    assign rd_in_range = {1'b0, rd_ch} < (CHW+1)'(NCH);
    assign accept      = lvl_wr_valid && lvl_wr_ready;
    assign scrub_done  = (scrub_cnt == SCW'(SCRUB_CYC - 1));

    always_comb begin
        wr_cur_lvl = '0;
        rd_cur_lvl = '0;
        rd_cur_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (lvl_wr_ch == CHW'(i)) wr_cur_lvl = lvl[i];
            if (rd_ch == CHW'(i)) begin
                rd_cur_lvl = lvl[i];
                rd_cur_cnt = cnt[i];
            end
        end
    end

    assign upgrade   = accept && wr_in_range &&
                       lvl_dominates(LVL_FN_W'(lvl_wr_val), LVL_FN_W'(wr_cur_lvl));
    assign downgrade = accept && wr_in_range &&
                       !lvl_dominates(LVL_FN_W'(lvl_wr_val), LVL_FN_W'(wr_cur_lvl));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (downgrade) next_state = SCRUB;
            SCRUB:   if (scrub_done) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The old level stays in force until the edge that leaves COMMIT.
    always_comb begin
        lvl_wr_ready = (state == IDLE);
        load_val     = (state == COMMIT) ? lat_val : lvl_wr_val;
        ch_clear     = '0;
        ch_load      = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_clear[i] = ((state != IDLE) && (lat_ch == CHW'(i))) ||
                          (downgrade && (lvl_wr_ch == CHW'(i)));
            ch_load[i]  = (upgrade && (lvl_wr_ch == CHW'(i))) ||
                          ((state == COMMIT) && (lat_ch == CHW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_cnt <= '0;
            lat_ch    <= '0;
            lat_val   <= '0;
        end else if (downgrade) begin
            scrub_cnt <= '0;
            lat_ch    <= lvl_wr_ch;
            lat_val   <= lvl_wr_val;
        end else if (state == SCRUB) begin
            scrub_cnt <= scrub_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tecb_channel #(.CW(CW), .LW(LW)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .inc      (evt[g]),
            .clear    (ch_clear[g]),
            .load     (ch_load[g]),
            .load_val (load_val),
            .cnt      (cnt[g]),
            .lvl      (lvl[g])
        );
        assign ch_lvl[g*LW +: LW] = lvl[g];
    end

    // Reads see the pre-edge counter and level, so same-cycle updates are not visible yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_resp_valid <= 1'b0;
            rd_data       <= '0;
            rd_denied     <= 1'b0;
        end else begin
            rd_resp_valid <= rd_valid;
            if (!rd_valid) begin
                rd_data   <= '0;
                rd_denied <= 1'b0;
            end else if (!rd_in_range ||
                         !lvl_dominates(LVL_FN_W'(rd_lvl), LVL_FN_W'(rd_cur_lvl))) begin
                rd_data   <= '0;
                rd_denied <= 1'b1;
            end else begin
                rd_data   <= rd_cur_cnt;
                rd_denied <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tagged_event_counter_bank.sv
// Directed and randomized checks of tagged_event_counter_bank against a behavioural model.
module tb_tagged_event_counter_bank;

    localparam int NCH       = 4;
    localparam int CW        = 4;
    localparam int LW        = 1;
    localparam int CHW       = 2;
    localparam int SCRUB_CYC = 2;
    localparam int MAXC      = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    evt;
    logic              lvl_wr_valid;
    logic              lvl_wr_ready;
    logic [CHW-1:0]    lvl_wr_ch;
    logic [LW-1:0]     lvl_wr_val;
    logic              rd_valid;
    logic [CHW-1:0]    rd_ch;
    logic [LW-1:0]     rd_lvl;
    logic              rd_resp_valid;
    logic [CW-1:0]     rd_data;
    logic              rd_denied;
    logic [NCH*LW-1:0] ch_lvl;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: counts, levels, and cycles left until a pending downgrade commits.
    int m_cnt [NCH];
    int m_lvl [NCH];
    int m_busy;
    int m_ch;
    int m_val;
    logic          exp_rv;
    logic [CW-1:0] exp_rd;
    logic          exp_den;

    tagged_event_counter_bank #(.NCH(NCH), .CW(CW), .LW(LW), .SCRUB_CYC(SCRUB_CYC)) dut (
        .clk           (clk),
        .reset         (reset),
        .evt           (evt),
        .lvl_wr_valid  (lvl_wr_valid),
        .lvl_wr_ready  (lvl_wr_ready),
        .lvl_wr_ch     (lvl_wr_ch),
        .lvl_wr_val    (lvl_wr_val),
        .rd_valid      (rd_valid),
        .rd_ch         (rd_ch),
        .rd_lvl        (rd_lvl),
        .rd_resp_valid (rd_resp_valid),
        .rd_data       (rd_data),
        .rd_denied     (rd_denied),
        .ch_lvl        (ch_lvl)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH*LW-1:0] model_lvl_vec();
        logic [NCH*LW-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i*LW +: LW] = LW'(m_lvl[i]);
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return #1 after the edge.
    task automatic step(input logic rst, input logic [NCH-1:0] e, input logic wv,
                        input logic [CHW-1:0] wch, input logic [LW-1:0] wval,
                        input logic rv, input logic [CHW-1:0] rch, input logic [LW-1:0] rl);
        reset = rst; evt = e; lvl_wr_valid = wv; lvl_wr_ch = wch; lvl_wr_val = wval;
        rd_valid = rv; rd_ch = rch; rd_lvl = rl;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_lvl[i] = 0; end
            m_busy = 0; exp_rv = 0; exp_rd = '0; exp_den = 0;
        end else begin
            exp_rv = rv; exp_rd = '0; exp_den = 0;
            if (rv) begin
                if (int'(rch) >= NCH || int'(rl) < m_lvl[rch]) exp_den = 1;
                else exp_rd = CW'(m_cnt[rch]);
            end
            for (int i = 0; i < NCH; i++) begin
                if (m_busy != 0 && i == m_ch) m_cnt[i] = 0;
                else if (e[i]) begin
`ifdef EVT_COUNT_SAT_EN
                    if (m_cnt[i] < MAXC) m_cnt[i] = m_cnt[i] + 1;
`else
                    m_cnt[i] = (m_cnt[i] + 1) % (MAXC + 1);
`endif
                end
            end
            if (m_busy != 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) m_lvl[m_ch] = m_val;
            end else if (wv && int'(wch) < NCH) begin
                if (int'(wval) >= m_lvl[wch]) m_lvl[wch] = int'(wval);
                else begin
                    m_cnt[wch] = 0; m_busy = SCRUB_CYC + 1; m_ch = int'(wch); m_val = int'(wval);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, '1, 1'b0, 0, 0, 1'b1, 0, 0);
        n_cmp++; if (lvl_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 1", lvl_wr_ready); end
        n_cmp++; if (rd_resp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rv: got %b want 0", rd_resp_valid); end
        n_cmp++; if (rd_data !== '0) begin n_err++; $display("[TB] FAIL reset_data: got %0d want 0", rd_data); end
        n_cmp++; if (rd_denied !== 1'b0) begin n_err++; $display("[TB] FAIL reset_denied: got %b want 0", rd_denied); end
        n_cmp++; if (ch_lvl !== '0) begin n_err++; $display("[TB] FAIL reset_lvl: got %b want 0", ch_lvl); end
    endtask

    task automatic test_count();
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0001, 0, 0, 0, 0, 0, 0);
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd0, 1'b0);
        n_cmp++; if (rd_resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL count_rv: got %b want 1", rd_resp_valid); end
        n_cmp++; if (rd_data !== 4'd5) begin n_err++; $display("[TB] FAIL count_data: got %0d want 5", rd_data); end
        n_cmp++; if (rd_denied !== 1'b0) begin n_err++; $display("[TB] FAIL count_denied: got %b want 0", rd_denied); end
        step(1'b0, '0, 0, 0, 0, 1'b0, 2'd0, 1'b0);
        n_cmp++; if ({rd_resp_valid, rd_data, rd_denied} !== '0) begin n_err++; $display("[TB] FAIL idle_read: got %b/%0d/%b want 0/0/0", rd_resp_valid, rd_data, rd_denied); end
    endtask

    task automatic test_level_raise();
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        step(1'b0, '0, 1'b1, 2'd1, 1'b1, 0, 0, 0);
        n_cmp++; if (ch_lvl !== 4'b0010) begin n_err++; $display("[TB] FAIL raise_lvl: got %b want 0010", ch_lvl); end
        n_cmp++; if (lvl_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL raise_ready: got %b want 1", lvl_wr_ready); end
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0010, 0, 0, 0, 0, 0, 0);
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd1, 1'b0);
        n_cmp++; if (rd_denied !== 1'b1 || rd_data !== '0) begin n_err++; $display("[TB] FAIL raise_deny: got %b/%0d want 1/0", rd_denied, rd_data); end
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd1, 1'b1);
        n_cmp++; if (rd_denied !== 1'b0 || rd_data !== 4'd3) begin n_err++; $display("[TB] FAIL raise_read: got %b/%0d want 0/3", rd_denied, rd_data); end
    endtask

    task automatic test_scrub();
        logic exp_lvl1;
        // Continues from test_level_raise: ch1 at level 1 holding 3, ch2 at 0.
        step(1'b0, 4'b0110, 1'b1, 2'd1, 1'b0, 0, 0, 0);
        n_cmp++; if (lvl_wr_ready !== 1'b0) begin n_err++; $display("[TB] FAIL scrub_ready0: got %b want 0", lvl_wr_ready); end
        n_cmp++; if (ch_lvl[1] !== 1'b1) begin n_err++; $display("[TB] FAIL scrub_oldlvl0: got %b want 1", ch_lvl[1]); end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0110, 1'b0, 0, 0, 1'b1, 2'd1, 1'b1);
            exp_lvl1 = (k < 2);
            n_cmp++; if (lvl_wr_ready !== !exp_lvl1) begin n_err++; $display("[TB] FAIL scrub_ready%0d: got %b want %b", k+1, lvl_wr_ready, !exp_lvl1); end
            n_cmp++; if (ch_lvl[1] !== exp_lvl1) begin n_err++; $display("[TB] FAIL scrub_lvl%0d: got %b want %b", k+1, ch_lvl[1], exp_lvl1); end
            n_cmp++; if (rd_data !== '0 || rd_denied !== 1'b0) begin n_err++; $display("[TB] FAIL scrub_read%0d: got %0d/%b want 0/0", k+1, rd_data, rd_denied); end
        end
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd2, 1'b0);
        n_cmp++; if (rd_data !== 4'd4) begin n_err++; $display("[TB] FAIL scrub_other: got %0d want 4", rd_data); end
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd1, 1'b0);
        n_cmp++; if (rd_data !== '0 || rd_denied !== 1'b0) begin n_err++; $display("[TB] FAIL scrub_after: got %0d/%b want 0/0", rd_data, rd_denied); end
    endtask

    task automatic test_wrap();
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) step(1'b0, 4'b0001, 0, 0, 0, 0, 0, 0);
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd0, 1'b0);
`ifdef EVT_COUNT_SAT_EN
        n_cmp++; if (rd_data !== 4'd15) begin n_err++; $display("[TB] FAIL sat_data: got %0d want 15", rd_data); end
`else
        n_cmp++; if (rd_data !== 4'd0) begin n_err++; $display("[TB] FAIL wrap_data: got %0d want 0", rd_data); end
`endif
    endtask

    task automatic test_back_to_back();
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(1'b0, 4'b0001, 0, 0, 0, 0, 0, 0);
        step(1'b0, 4'b0001, 0, 0, 0, 1'b1, 2'd0, 1'b0);
        n_cmp++; if (rd_data !== 4'd7) begin n_err++; $display("[TB] FAIL b2b_pre: got %0d want 7", rd_data); end
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd0, 1'b0);
        n_cmp++; if (rd_data !== 4'd8) begin n_err++; $display("[TB] FAIL b2b_post: got %0d want 8", rd_data); end
    endtask

    task automatic test_reset_mid_scrub();
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 0, 0, 0);
        step(1'b0, 4'b1111, 0, 0, 0, 0, 0, 0);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 0, 0);
        step(1'b0, 4'b1111, 0, 0, 0, 1'b1, 2'd2, 1'b0);
        step(1'b1, 4'b1111, 0, 0, 0, 1'b1, 2'd2, 1'b0);
        n_cmp++; if (lvl_wr_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_ready: got %b want 1", lvl_wr_ready); end
        n_cmp++; if (ch_lvl !== '0) begin n_err++; $display("[TB] FAIL midrst_lvl: got %b want 0", ch_lvl); end
        n_cmp++; if ({rd_resp_valid, rd_data, rd_denied} !== '0) begin n_err++; $display("[TB] FAIL midrst_read: got %b/%0d/%b want 0/0/0", rd_resp_valid, rd_data, rd_denied); end
        step(1'b0, '0, 0, 0, 0, 1'b1, 2'd2, 1'b0);
        n_cmp++; if (rd_data !== '0 || rd_resp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_cnt: got %0d/%b want 0/1", rd_data, rd_resp_valid); end
    endtask

    task automatic test_random();
        logic exp_ready;
        step(1'b1, '0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            exp_ready = (m_busy == 0);
            n_cmp++; if (lvl_wr_ready !== exp_ready) begin n_err++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", k, lvl_wr_ready, exp_ready); end
            step(1'b0, NCH'($urandom), ($urandom_range(0, 3) == 0), CHW'($urandom),
                 LW'($urandom), ($urandom_range(0, 1) == 1), CHW'($urandom), LW'($urandom));
            n_cmp++; if (rd_resp_valid !== exp_rv) begin n_err++; $display("[TB] FAIL rnd_rv@%0d: got %b want %b", k, rd_resp_valid, exp_rv); end
            n_cmp++; if (rd_data !== exp_rd) begin n_err++; $display("[TB] FAIL rnd_data@%0d: got %0d want %0d", k, rd_data, exp_rd); end
            n_cmp++; if (rd_denied !== exp_den) begin n_err++; $display("[TB] FAIL rnd_denied@%0d: got %b want %b", k, rd_denied, exp_den); end
            n_cmp++; if (ch_lvl !== model_lvl_vec()) begin n_err++; $display("[TB] FAIL rnd_lvl@%0d: got %b want %b", k, ch_lvl, model_lvl_vec()); end
        end
    endtask

    initial begin
        reset = 1'b1; evt = '0; lvl_wr_valid = 1'b0; lvl_wr_ch = '0; lvl_wr_val = '0;
        rd_valid = 1'b0; rd_ch = '0; rd_lvl = '0;
        test_reset();
        test_count();
        test_level_raise();
        test_scrub();
        test_wrap();
        test_back_to_back();
        test_reset_mid_scrub();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
